// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bi, one bit per clock, LSB first.
// Optional macro SERIAL_SUB_OVF_EN adds a registered signed-overflow output ovf.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d, b_sr_q, b_sr_d;
  logic [WIDTH-1:0] diff_sr_q, diff_sr_d, diff_q, diff_d;
  logic             brw_q, brw_d, borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             x, y, c, rbit, nbrw, last;

  // Full-subtractor cell on the current operand LSBs and the borrow flop
  assign x    = a_sr_q[0];
  assign y    = b_sr_q[0];
  assign c    = brw_q;
  assign rbit = x ^ y ^ c;
  assign nbrw = (~x & y) | (~x & c) | (y & c);
  assign last = (cnt_q == CW'(WIDTH - 1));

`ifdef SERIAL_SUB_OVF_EN
  logic amsb_q, amsb_d, bmsb_q, bmsb_d, ovf_q, ovf_d;
`endif

  always_comb begin
    state_d   = state_q;
    a_sr_d    = a_sr_q;
    b_sr_d    = b_sr_q;
    diff_sr_d = diff_sr_q;
    diff_d    = diff_q;
    brw_d     = brw_q;
    borrow_d  = borrow_q;
    cnt_d     = cnt_q;
`ifdef SERIAL_SUB_OVF_EN
    amsb_d    = amsb_q;
    bmsb_d    = bmsb_q;
    ovf_d     = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d    = a;
          b_sr_d    = b;
          brw_d     = bi;
          diff_sr_d = '0;
          cnt_d     = '0;
`ifdef SERIAL_SUB_OVF_EN
          amsb_d    = a[WIDTH-1];
          bmsb_d    = b[WIDTH-1];
`endif
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        a_sr_d    = a_sr_q >> 1;
        b_sr_d    = b_sr_q >> 1;
        brw_d     = nbrw;
        diff_sr_d = {rbit, diff_sr_q[WIDTH-1:1]};
        cnt_d     = cnt_q + CW'(1);
        // Outputs only update on the final bit, so they hold across later ops
        if (last) begin
          diff_d   = {rbit, diff_sr_q[WIDTH-1:1]};
          borrow_d = nbrw;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d    = (amsb_q != bmsb_q) && (rbit != amsb_q);
`endif
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      a_sr_q    <= '0;
      b_sr_q    <= '0;
      diff_sr_q <= '0;
      diff_q    <= '0;
      brw_q     <= 1'b0;
      borrow_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      a_sr_q    <= a_sr_d;
      b_sr_q    <= b_sr_d;
      diff_sr_q <= diff_sr_d;
      diff_q    <= diff_d;
      brw_q     <= brw_d;
      borrow_q  <= borrow_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      amsb_q <= 1'b0;
      bmsb_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      amsb_q <= amsb_d;
      bmsb_q <= bmsb_d;
      ovf_q  <= ovf_d;
    end
  end
  assign ovf = ovf_q;
`endif

  assign busy   = (state_q == SHIFT);
  assign done   = (state_q == DONE);
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Table-driven bench for serial_subtractor with an expected-result queue.
module tb_serial_subtractor;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset, start, bi;
  logic [W-1:0] a, b;
  logic         busy, done, borrow;
  logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [W-1:0] a, b;
    logic         bi;
    logic [W-1:0] d;
    logic         br, ov;
  } vec_t;

  typedef struct packed {
    logic [W-1:0] d;
    logic         br, ov;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[6];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .bi(bi),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Independent reference: WIDTH+1-bit unsigned subtract, plus signed overflow
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbi);
    logic [W:0] r;
    exp_t e;
    r    = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbi};
    e.d  = r[W-1:0];
    e.br = r[W];
    e.ov = (ma[W-1] != mb[W-1]) && (r[W-1] != ma[W-1]);
    return e;
  endfunction

  // Drive operands with start at a negedge; returns just after the accept edge
  task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbi, input exp_t e);
    a = ta; b = tb_; bi = tbi; start = 1'b1;
    sbq.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int exp_lat);
    int n;
    exp_t e;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " latency"}, n, exp_lat);
    if (done !== 1'b1) return;
    chk({nm, " busy"}, {31'd0, busy}, 32'd0);
    if (sbq.size() == 0) begin
      chk({nm, " queue"}, 32'd0, 32'd1);
      return;
    end
    e = sbq.pop_front();
    chk({nm, " diff"}, {28'd0, diff}, {28'd0, e.d});
    chk({nm, " borrow"}, {31'd0, borrow}, {31'd0, e.br});
`ifdef SERIAL_SUB_OVF_EN
    chk({nm, " ovf"}, {31'd0, ovf}, {31'd0, e.ov});
`endif
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    vecs[0] = '{a: 4'd10, b: 4'd2,  bi: 1'b0, d: 4'd8,  br: 1'b0, ov: 1'b0};
    vecs[1] = '{a: 4'd2,  b: 4'd10, bi: 1'b0, d: 4'd8,  br: 1'b1, ov: 1'b1};
    vecs[2] = '{a: 4'd10, b: 4'd2,  bi: 1'b1, d: 4'd7,  br: 1'b0, ov: 1'b1};
    vecs[3] = '{a: 4'd0,  b: 4'd0,  bi: 1'b1, d: 4'hF,  br: 1'b1, ov: 1'b0};
    vecs[4] = '{a: 4'd8,  b: 4'd1,  bi: 1'b0, d: 4'd7,  br: 1'b0, ov: 1'b1};
    vecs[5] = '{a: 4'd5,  b: 4'd3,  bi: 1'b0, d: 4'd2,  br: 1'b0, ov: 1'b0};

    reset = 1'b1; start = 1'b0; a = '0; b = '0; bi = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset diff", {28'd0, diff}, 32'd0);
    chk("reset borrow", {31'd0, borrow}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      e = '{d: vecs[i].d, br: vecs[i].br, ov: vecs[i].ov};
      launch(vecs[i].a, vecs[i].b, vecs[i].bi, e);
      chk($sformatf("vec%0d busy", i), {31'd0, busy}, 32'd1);
      wait_done($sformatf("vec%0d", i), W);
    end

    // start during SHIFT is dropped and not queued
    launch(4'd10, 4'd2, 1'b0, '{d: 4'd8, br: 1'b0, ov: 1'b0});
    @(negedge clk);
    a = 4'd1; b = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore", W - 2);
    chk("ignore idle busy", {31'd0, busy}, 32'd0);
    chk("ignore idle done", {31'd0, done}, 32'd0);

    // Asynchronous reset mid-SHIFT, between edges
    a = 4'd15; b = 4'd1; bi = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async busy", {31'd0, busy}, 32'd0);
    chk("async done", {31'd0, done}, 32'd0);
    chk("async diff", {28'd0, diff}, 32'd0);
    chk("async borrow", {31'd0, borrow}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    launch(4'd5, 4'd3, 1'b0, model(4'd5, 4'd3, 1'b0));
    wait_done("post reset", W);

    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int ic = 0; ic < 2; ic++) begin
          launch(4'(ia), 4'(ib), 1'(ic), model(4'(ia), 4'(ib), 1'(ic)));
          wait_done($sformatf("sweep %0d-%0d-%0d", ia, ib, ic), W);
        end

    chk("queue empty", sbq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
